// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MUL, DIVU, REMU,
// with registered results and flags presented behind a valid/ready handshake.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             f,
    output logic             v,
    output logic             dz,
    output logic             err
);
    localparam int unsigned SH = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_EXEC, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ra, rb, md, sh, acc;
    logic [3:0]       rc;
    logic [SH-1:0]    cnt;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff, acc_nx, sh_nx, md_nx;
    logic [WIDTH-1:0] sum, diff, res;
    logic             undef, vflag, dzflag;

    // One iteration: MUL uses acc as product, sh as multiplier, md as shifted multiplicand.
    // DIVU/REMU use acc as partial remainder and sh as dividend shifting into quotient.
    always_comb begin
        rem_sh   = {acc, sh[WIDTH-1]};
        rem_diff = rem_sh[WIDTH-1:0] - rb;
        acc_nx   = acc;
        sh_nx    = sh;
        md_nx    = md;
        if (rc == 4'd8) begin
            acc_nx = sh[0] ? acc + md : acc;
            sh_nx  = sh >> 1;
            md_nx  = md << 1;
        end else if (rem_sh >= {1'b0, rb}) begin
            acc_nx = rem_diff;
            sh_nx  = {sh[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx = rem_sh[WIDTH-1:0];
            sh_nx  = {sh[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        sum   = ra + rb;
        diff  = ra - rb;
        res   = '0;
        undef = 1'b0;
        case (rc)
            4'd0:    res = ra & rb;
            4'd1:    res = ra | rb;
            4'd2:    res = sum;
            4'd3:    res = ra << rb[SH-1:0];
            4'd4:    res = ra >> rb[SH-1:0];
            4'd5:    res = $signed(ra) >>> rb[SH-1:0];
            4'd6:    res = diff;
            4'd7:    res[0] = $signed(ra) < $signed(rb);
            4'd8:    res = acc;
            4'd9:    res = sh;
            4'd10:   res = acc;
            4'd12:   res = ~(ra | rb);
            default: undef = 1'b1;
        endcase
        vflag = 1'b0;
        if (rc == 4'd2)
            vflag = (ra[WIDTH-1] == rb[WIDTH-1]) && (sum[WIDTH-1] != ra[WIDTH-1]);
        else if (rc == 4'd6)
            vflag = (ra[WIDTH-1] != rb[WIDTH-1]) && (diff[WIDTH-1] != ra[WIDTH-1]);
        dzflag = ((rc == 4'd9) || (rc == 4'd10)) && (rb == '0);
    end

    // Accept and iterative cycles are followed by an EXEC cycle that registers the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            z         <= 1'b0;
            f         <= 1'b0;
            v         <= 1'b0;
            dz        <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            ra        <= '0;
            rb        <= '0;
            rc        <= '0;
            md        <= '0;
            sh        <= '0;
            acc       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ra       <= a;
                        rb       <= b;
                        rc       <= c;
                        md       <= a;
                        sh       <= (c == 4'd8) ? b : a;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        if (c >= 4'd8 && c <= 4'd10) begin
                            state <= S_BUSY;
                            cnt   <= SH'(WIDTH - 1);
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_BUSY: begin
                    acc <= acc_nx;
                    sh  <= sh_nx;
                    md  <= md_nx;
                    if (cnt == '0)
                        state <= S_EXEC;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_EXEC: begin
                    out       <= res;
                    z         <= (res == '0);
                    f         <= res[WIDTH-1];
                    v         <= vflag;
                    dz        <= dzflag;
                    err       <= undef;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
